// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared op codes, FSM states and constants for the ALU controller
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ILLEGAL_RESULT = 0;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - W-bit adder/subtractor; sub inverts b and injects a carry-in of 1
module alu_addsub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - ALU sequencer: valid/ready command intake, single-cycle ops,
// shift-add multiply, and a held result until the consumer accepts it
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           zero,
  output logic           err,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [N-1:0]     a_q, b_q, mplier_q;
  logic [2*N-1:0]   mcand_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             cmd_fire;

  logic [N-1:0]     ex_sum;
  logic             ex_carry;
  logic [N-1:0]     ex_result;
  logic             ex_c;
  logic             ex_err;
  logic [2*N-1:0]   mul_sum;
  logic             mul_carry_unused;

  assign cmd_fire = cmd_valid && cmd_ready;

  alu_addsub #(.W(N)) u_exec_addsub (
    .a     (a_q),
    .b     (b_q),
    .sub   (op_q == OP_SUB),
    .sum   (ex_sum),
    .carry (ex_carry)
  );

  // Product fits in 2N bits, so the accumulator carry-out is always 0.
  alu_addsub #(.W(2*N)) u_mul_addsub (
    .a     (acc_q),
    .b     (mplier_q[0] ? mcand_q : '0),
    .sub   (1'b0),
    .sum   (mul_sum),
    .carry (mul_carry_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (op_t'(op) == OP_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_result = '0;
    ex_c      = 1'b0;
    ex_err    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        ex_result = ex_sum;
        ex_c      = ex_carry;
      end
      OP_AND:  ex_result = a_q & b_q;
      OP_OR:   ex_result = a_q | b_q;
      OP_XOR:  ex_result = a_q ^ b_q;
      default: begin
        ex_result = N'(ILLEGAL_RESULT);
        ex_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_fire) begin
          op_q     <= op_t'(op);
          a_q      <= a;
          b_q      <= b;
          mcand_q  <= {{N{1'b0}}, a};
          mplier_q <= b;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        EXEC: begin
          result <= {{N{1'b0}}, ex_result};
          carry  <= ex_c;
          zero   <= (ex_result == '0);
          err    <= ex_err;
        end
        MUL: begin
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result <= mul_sum;
            carry  <= 1'b0;
            zero   <= (mul_sum == '0);
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed self-checking bench for alu_ctrl (N=4)
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_ctrl #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Called 1ns after a rising edge with the DUT idle; returns 1ns after the handshake edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    op = o; a = x; b = y; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({res_valid, busy, cmd_ready, result, carry, zero, err} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rv=%b busy=%b rdy=%b res=%h c=%b z=%b e=%b, want rv=0 busy=0 rdy=1 res=00 c=0 z=0 e=0",
               res_valid, busy, cmd_ready, result, carry, zero, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(3'b000, 4'd9, 4'd8);
    tests_run++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_exec_cycle: got busy=%b rv=%b, want busy=1 rv=0", busy, res_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, result, carry, zero, err} !== {1'b1, 8'h01, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_9_8: got rv=%b res=%h c=%b z=%b e=%b, want rv=1 res=01 c=1 z=0 e=0",
               res_valid, result, carry, zero, err);
    end
    accept();
  endtask

  task automatic test_sub();
    issue(3'b001, 4'd5, 4'd5);
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, result, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub_5_5: got rv=%b res=%h c=%b z=%b, want rv=1 res=00 c=1 z=1", res_valid, result, carry, zero);
    end
    accept();
    issue(3'b001, 4'd3, 4'd5);
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, result, carry, zero} !== {1'b1, 8'h0E, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub_3_5: got rv=%b res=%h c=%b z=%b, want rv=1 res=0e c=0 z=0", res_valid, result, carry, zero);
    end
    accept();
  endtask

  task automatic test_logic();
    logic [2:0] ops [3]  = '{3'b010, 3'b011, 3'b100};
    logic [7:0] want [3] = '{8'h08, 8'h0E, 8'h06};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 4'hC, 4'hA);
      @(posedge clk); #1;
      tests_run++;
      if ({res_valid, result, carry, err} !== {1'b1, want[i], 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL logic_op%0d: got rv=%b res=%h c=%b e=%b, want rv=1 res=%h c=0 e=0",
                 ops[i], res_valid, result, carry, err, want[i]);
      end
      accept();
    end
  endtask

  task automatic test_mul();
    int busy_cycles = 0;
    issue(3'b101, 4'd15, 4'd15);
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1 && res_valid === 1'b0) busy_cycles++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (busy_cycles != 4) begin
      tests_failed++;
      $display("FAIL mul_busy_cycles: got %0d, want 4", busy_cycles);
    end
    tests_run++;
    if ({res_valid, busy, result, carry, zero, err} !== {1'b1, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mul_15_15: got rv=%b busy=%b res=%h c=%b z=%b e=%b, want rv=1 busy=0 res=e1 c=0 z=0 e=0",
               res_valid, busy, result, carry, zero, err);
    end
    accept();
    issue(3'b101, 4'd0, 4'd9);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if ({res_valid, result, zero} !== {1'b1, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL mul_0_9: got rv=%b res=%h z=%b, want rv=1 res=00 z=1", res_valid, result, zero);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue(3'b000, 4'd1, 4'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 1); op = 3'b011; a = 4'hF; b = 4'hF;
      if ({res_valid, cmd_ready, result, carry, zero, err} !== {1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0}) bad++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests_run++;
    if (bad != 0 || result !== 8'h03 || res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_hold: got %0d bad cycles, res=%h rv=%b, want 0 bad, res=03 rv=1", bad, result, res_valid);
    end
    accept();
    tests_run++;
    if ({cmd_ready, res_valid, busy} !== {1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL backpressure_release: got rdy=%b rv=%b busy=%b, want rdy=1 rv=0 busy=0", cmd_ready, res_valid, busy);
    end
  endtask

  task automatic test_illegal();
    issue(3'b110, 4'd7, 4'd1);
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, result, err, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL illegal_op: got rv=%b res=%h e=%b c=%b z=%b, want rv=1 res=00 e=1 c=0 z=1",
               res_valid, result, err, carry, zero);
    end
    accept();
    issue(3'b000, 4'd1, 4'd1);
    @(posedge clk); #1;
    tests_run++;
    if ({res_valid, result, err, carry, zero} !== {1'b1, 8'h02, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL illegal_then_add: got rv=%b res=%h e=%b c=%b z=%b, want rv=1 res=02 e=0 c=0 z=0",
               res_valid, result, err, carry, zero);
    end
    accept();
  endtask

  task automatic test_mul_reset();
    issue(3'b101, 4'd15, 4'd15);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({res_valid, busy, cmd_ready, result, carry, zero, err} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mul_async_reset: got rv=%b busy=%b rdy=%b res=%h c=%b z=%b e=%b, want rv=0 busy=0 rdy=1 res=00 c=0 z=0 e=0",
               res_valid, busy, cmd_ready, result, carry, zero, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'b101, 4'd3, 4'd4);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if ({res_valid, result, carry, zero} !== {1'b1, 8'h0C, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mul_after_reset: got rv=%b res=%h c=%b z=%b, want rv=1 res=0c c=0 z=0", res_valid, result, carry, zero);
    end
    accept();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; op = 3'b000; a = 4'd0; b = 4'd0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_illegal();
    test_mul_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequencing controller for the lab ALU datapath.
- Accepts one operation request at a time over a valid/ready handshake and latches the operands.
- Runs single-cycle ops (add, subtract, logic) in one EXEC cycle, and multiply as an N-cycle shift-add loop on one shared adder/subtractor.
- Holds the registered result and flags until the consumer accepts them.
- Sits between the board-level input logic (switches/buttons) and the display/flag outputs.

Parameters:
N, 4, operand width in bits; result width is 2N.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  requester has a command.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
op  input  3  operation code, sampled on handshake.
a  input  N  operand A, sampled on handshake.
b  input  N  operand B, sampled on handshake.
res_valid  output  1  result and flags are valid.
res_ready  input  1  consumer accepts the result.
result  output  2N  registered result.
carry  output  1  adder carry-out; for SUB, no-borrow.
zero  output  1  result == 0.
err  output  1  illegal op code.
busy  output  1  high in EXEC or MUL.

Behaviour:
- Op codes:
  - 000 ADD
  - 001 SUB (a + ~b + 1)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL (unsigned)
  - 110 and 111 illegal.
- States: IDLE, EXEC, MUL, DONE.
- Reset (asynchronous, any state, including mid-MUL): state=IDLE, result=0, carry=0, zero=0, err=0, res_valid=0, busy=0, cmd_ready=1. Internal operand, multiplier, counter and accumulator registers clear to 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready at edge k: latch op/a/b.
  - Next state is MUL if op=101, otherwise EXEC.
  - cmd_valid low: stay in IDLE.
- EXEC (one cycle):
  - Compute via the shared add/sub unit or logic ops.
  - At edge k+1: register result, zero-extended from N bits, plus flags, then go to DONE.
  - ADD/SUB: carry = adder carry-out. Logic ops: carry=0.
  - Illegal op: result=0, carry=0, err=1.
  - Non-illegal ops: err=0.
- MUL:
  - Accumulator 2N bits, multiplicand shifted left each iteration, multiplier shifted right, counter 0..N-1.
  - At each edge, if the multiplier LSB=1, add the shifted multiplicand into the accumulator through the shared adder, extended to 2N.
  - After N iterations (edges k+1..k+N), register result=a*b, carry=0, err=0, then go to DONE.
  - Latency from handshake edge to res_valid: N edges. For N=4, res_valid rises after edge k+4.
- DONE:
  - res_valid=1; result/flags held stable.
  - On res_ready at an edge: go to IDLE and clear res_valid.
  - cmd_ready=0 in DONE, so a new command cannot be accepted in the same cycle as result acceptance.
- zero is computed on the full 2N-bit registered result.
- Flags are updated only when a result is registered, never in IDLE.
- cmd_valid and operand changes while not in IDLE are ignored.
- busy=1 exactly in EXEC and MUL.
- Arithmetic wraps modulo 2^N for ADD/SUB; MUL never overflows 2N bits.

Decomposition:
- Package alu_ctrl_pkg:
  - op_t enum with the op codes above.
  - state_t enum {IDLE, EXEC, MUL, DONE}.
  - Constant for the illegal-op result value (0).
- Sub-module alu_addsub: parameterised W-bit adder with a sub input (inverts b, carry-in=1). It returns sum and carry-out.
  - EXEC uses it with W=N.
  - MUL accumulation uses it with W=2N.

Test Plan:
- ADD, N=4, a=9, b=8 -> after 1 EXEC cycle: res_valid=1, result=0x01, carry=1, zero=0, err=0.
- SUB a=5, b=5 -> result=0x00, zero=1, carry=1. SUB a=3, b=5 -> result=0x0E, carry=0, zero=0.
- MUL a=15, b=15 -> busy high 4 cycles; res_valid after edge k+4 with result=0xE1, carry=0. Check MUL a=0, b=9 -> result=0, zero=1.
- Backpressure: hold res_ready=0 for 5 cycles after any result -> result/flags stable, cmd_ready=0; a cmd_valid pulse with new operands is ignored. Raise res_ready -> IDLE next edge, cmd_ready=1.
- Illegal op 110, a=7, b=1 -> result=0, err=1, carry=0, zero=1. A following legal ADD clears err.
- Assert rst mid-MUL (after edge k+2) -> all outputs immediately 0, cmd_ready=1. A fresh MUL 3*4 after release -> result=0x0C.
